// File: rtl/regfile_pkg.sv
// regfile_pkg: shared FSM state type and default geometry for the 2-read/1-write register file
package regfile_pkg;
  typedef enum logic {RF_CLEAR, RF_RUN} rf_state_t;
  localparam int RF_WIDTH = 32;
  localparam int RF_ADDR_W = 6;
endpackage

// File: rtl/regfile_param_2r1w_if.sv
// regfile_param_2r1w_if: register file bus (rAddr1/rDout1, rAddr2/rDout2, wAddr/wDin/wEna, ready); master drives addresses and writes, slave returns data and ready
interface regfile_param_2r1w_if import regfile_pkg::*; #(
  parameter int WIDTH = RF_WIDTH,
  parameter int ADDR_W = RF_ADDR_W
);
  logic [ADDR_W-1:0] rAddr1, rAddr2, wAddr;
  logic [WIDTH-1:0] rDout1, rDout2, wDin;
  logic wEna, ready;
  modport master (output rAddr1, rAddr2, wAddr, wDin, wEna, input rDout1, rDout2, ready);
  modport slave (input rAddr1, rAddr2, wAddr, wDin, wEna, output rDout1, rDout2, ready);
endinterface

// File: rtl/regfile_clear_ctrl.sv
// regfile_clear_ctrl: CLEAR/RUN FSM sweeping every entry with INIT_VAL after reset; ports clk, rst, clr_we_o/clr_addr_o/clr_data_o (clear write), ready_o
module regfile_clear_ctrl import regfile_pkg::*; #(
  parameter int WIDTH = RF_WIDTH,
  parameter int ADDR_W = RF_ADDR_W,
  parameter logic [WIDTH-1:0] INIT_VAL = '0
) (
  input  logic clk,
  input  logic rst,
  output logic clr_we_o,
  output logic [ADDR_W-1:0] clr_addr_o,
  output logic [WIDTH-1:0] clr_data_o,
  output logic ready_o
);
  rf_state_t state_q, state_d;
  logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;
  logic ready_q, ready_d;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RF_CLEAR;
      clr_ptr_q <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      clr_ptr_q <= clr_ptr_d;
      ready_q <= ready_d;
    end
  end
  always_comb begin
    state_d = (state_q == RF_CLEAR && &clr_ptr_q) ? RF_RUN : state_q;
    clr_ptr_d = (state_q == RF_CLEAR) ? clr_ptr_q + 1'b1 : clr_ptr_q;
    ready_d = (state_d == RF_RUN);
  end
  assign clr_we_o = (state_q == RF_CLEAR) && !rst;
  assign clr_addr_o = clr_ptr_q;
  assign clr_data_o = INIT_VAL;
  assign ready_o = ready_q;
endmodule

// File: rtl/regfile_param_2r1w.sv
// regfile_param_2r1w: 2**ADDR_W x WIDTH register file, two combinational read ports with write-first bypass, one write port, counter-driven clear; ports clk, rst, bus (slave); REGFILE_ZERO_REG_EN hardwires entry 0 to zero
module regfile_param_2r1w import regfile_pkg::*; #(
  parameter int WIDTH = RF_WIDTH,
  parameter int ADDR_W = RF_ADDR_W,
  parameter logic [WIDTH-1:0] INIT_VAL = '0
) (
  input logic clk,
  input logic rst,
  regfile_param_2r1w_if.slave bus
);
`ifdef REGFILE_ZERO_REG_EN
  localparam bit ZERO_REG = 1'b1;
`else
  localparam bit ZERO_REG = 1'b0;
`endif
  logic [WIDTH-1:0] mem_q [2**ADDR_W];
  logic clr_we, we, ready;
  logic [ADDR_W-1:0] clr_addr, w_addr;
  logic [WIDTH-1:0] clr_data, w_data;
  regfile_clear_ctrl #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .INIT_VAL(INIT_VAL)) u_clr (
    .clk(clk),
    .rst(rst),
    .clr_we_o(clr_we),
    .clr_addr_o(clr_addr),
    .clr_data_o(clr_data),
    .ready_o(ready)
  );
  always_comb begin
    we = clr_we || (ready && bus.wEna && !rst && !(ZERO_REG && bus.wAddr == '0));
    w_addr = clr_we ? clr_addr : bus.wAddr;
    w_data = clr_we ? clr_data : bus.wDin;
  end
  always_ff @(posedge clk) begin
    if (we) mem_q[w_addr] <= w_data;
  end
  always_comb begin
    bus.rDout1 = !ready ? INIT_VAL : (ZERO_REG && bus.rAddr1 == '0) ? '0 :
                 (bus.wEna && bus.rAddr1 == bus.wAddr) ? bus.wDin : mem_q[bus.rAddr1];
    bus.rDout2 = !ready ? INIT_VAL : (ZERO_REG && bus.rAddr2 == '0) ? '0 :
                 (bus.wEna && bus.rAddr2 == bus.wAddr) ? bus.wDin : mem_q[bus.rAddr2];
  end
  assign bus.ready = ready;
endmodule

// File: tb/tb_regfile_param_2r1w.sv
// tb_regfile_param_2r1w: directed stimulus with expectation queue drained by a negedge monitor
module tb_regfile_param_2r1w;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  int sel_q[$];
  logic [31:0] exp_q[$];
  string name_q[$];
  regfile_param_2r1w_if #(.WIDTH(32), .ADDR_W(6)) bus ();
  regfile_param_2r1w #(.WIDTH(32), .ADDR_W(6), .INIT_VAL(32'h0)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );
  always #5 clk = ~clk;
`ifdef REGFILE_ZERO_REG_EN
  localparam logic [31:0] ZEXP = 32'h0;
`else
  localparam logic [31:0] ZEXP = 32'h55;
`endif
  always @(negedge clk) begin
    while (sel_q.size() > 0) begin
      int s;
      logic [31:0] e, a;
      string n;
      s = sel_q.pop_front();
      e = exp_q.pop_front();
      n = name_q.pop_front();
      a = (s == 0) ? bus.rDout1 : (s == 1) ? bus.rDout2 : {31'b0, bus.ready};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
      end
    end
  end
  task automatic chk(input int s, input logic [31:0] e, input string n);
    sel_q.push_back(s);
    exp_q.push_back(e);
    name_q.push_back(n);
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic clear_run(input string n);
    for (int i = 1; i <= 64; i++) begin
      step();
      chk(2, {31'b0, i == 64}, n);
    end
  endtask
  initial begin
    bus.rAddr1 = '0;
    bus.rAddr2 = '0;
    bus.wAddr = '0;
    bus.wDin = '0;
    bus.wEna = 1'b0;
    step();
    step();
    rst = 1'b0;
    bus.rAddr1 = 6'd17;
    chk(2, 32'h0, "reset_ready");
    chk(0, 32'h0, "reset_rdout1");
    for (int i = 1; i <= 64; i++) begin
      step();
      bus.wEna = (i == 10);
      bus.wAddr = 6'd3;
      bus.wDin = 32'hFF;
      bus.rAddr1 = 6'd3;
      chk(2, {31'b0, i == 64}, "clear_timing");
      if (i == 10) chk(0, 32'h0, "clear_no_bypass");
    end
    bus.wEna = 1'b0;
    bus.rAddr1 = 6'd0;
    bus.rAddr2 = 6'd17;
    chk(0, 32'h0, "clear_addr0");
    chk(1, 32'h0, "clear_addr17");
    step();
    bus.rAddr1 = 6'd63;
    bus.rAddr2 = 6'd3;
    chk(0, 32'h0, "clear_addr63");
    chk(1, 32'h0, "clear_write_ignored");
    step();
    bus.wEna = 1'b1;
    bus.wAddr = 6'd5;
    bus.wDin = 32'hDEADBEEF;
    bus.rAddr1 = 6'd5;
    bus.rAddr2 = 6'd6;
    chk(0, 32'hDEADBEEF, "wr5_bypass");
    chk(1, 32'h0, "wr5_other");
    step();
    bus.wEna = 1'b0;
    chk(0, 32'hDEADBEEF, "rd5");
    chk(1, 32'h0, "rd6");
    step();
    bus.wEna = 1'b1;
    bus.wAddr = 6'd9;
    bus.wDin = 32'h12345678;
    bus.rAddr1 = 6'd9;
    bus.rAddr2 = 6'd9;
    chk(0, 32'h12345678, "bypass_p1");
    chk(1, 32'h12345678, "bypass_p2");
    step();
    bus.wEna = 1'b0;
    chk(0, 32'h12345678, "rd9_p1");
    chk(1, 32'h12345678, "rd9_p2");
    step();
    bus.wEna = 1'b1;
    bus.wAddr = 6'd9;
    bus.wDin = 32'h0BADF00D;
    bus.rAddr1 = 6'd5;
    bus.rAddr2 = 6'd9;
    chk(0, 32'hDEADBEEF, "bypass_indep_p1");
    chk(1, 32'h0BADF00D, "bypass_indep_p2");
    step();
    bus.wEna = 1'b1;
    bus.wAddr = 6'd0;
    bus.wDin = 32'h55;
    bus.rAddr1 = 6'd0;
    bus.rAddr2 = 6'd9;
    chk(0, ZEXP, "zero_reg_bypass");
    chk(1, 32'h0BADF00D, "rd9_updated");
    step();
    bus.wEna = 1'b0;
    chk(0, ZEXP, "zero_reg_read");
    step();
    bus.wEna = 1'b1;
    bus.wAddr = 6'd7;
    bus.wDin = 32'hA5A5A5A5;
    step();
    bus.wEna = 1'b0;
    bus.rAddr1 = 6'd7;
    chk(0, 32'hA5A5A5A5, "rd7_before_rst");
    chk(2, 32'h1, "ready_before_rst");
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk(2, 32'h0, "run_rst_ready");
    chk(0, 32'h0, "run_rst_rdout");
    clear_run("run_rst_timing");
    chk(0, 32'h0, "rd7_cleared");
    chk(1, 32'h0, "rd9_cleared");
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 1; i <= 30; i++) begin
      step();
      chk(2, 32'h0, "clear_pre_rst");
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk(2, 32'h0, "clear_rst_ready");
    clear_run("clear_rst_timing");
    bus.rAddr1 = 6'd5;
    chk(0, 32'h0, "rd5_cleared");
    @(negedge clk);
    #1;
    if (sel_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", sel_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
